// File: rtl/fft_input_reorder.sv
// rtl/fft_input_reorder.sv - 8-point FFT input reorder buffer feeding stage-1 butterflies
//
// Collects a frame of 8 complex samples x0..x7 in arrival order and emits four
// butterfly operand pairs in bit-reversed order: (x0,x4), (x2,x6), (x1,x5), (x3,x7).
// Samples pass bit-exact.
//
// Ports:
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready  input sample handshake, sample on in_re/in_im (W bits each)
//   out_valid/out_ready butterfly pair handshake
//   a_re/a_im/b_re/b_im registered operands a and b of the current pair
//   out_idx            pair index within the frame (0..3)
//   frame_last         high with pair 3
//
// Build option FFT_PINGPONG_EN: two 8-entry banks, the next frame loads while the
// current one emits, and consecutive frames emit without an out_valid bubble.
// Without it a single bank is used and input is refused while emitting.

module fft_input_reorder #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_re,
   input  logic [W-1:0] in_im,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] a_re,
   output logic [W-1:0] a_im,
   output logic [W-1:0] b_re,
   output logic [W-1:0] b_im,
   output logic [1:0]   out_idx,
   output logic         frame_last
);

   typedef enum logic {LOAD = 1'b0, EMIT = 1'b1} state_t;

`ifdef FFT_PINGPONG_EN
   localparam int AW = 4;
`else
   localparam int AW = 3;
`endif
   localparam int DEPTH = 1 << AW;

   state_t        state;
   logic [2:0]    count;
   logic [1:0]    pair_idx;
   logic [W-1:0]  mem_re [DEPTH];
   logic [W-1:0]  mem_im [DEPTH];

   logic          in_fire;
   logic          out_fire;
   logic          load_done;
   logic          last_pair;
   logic          swap_now;
   logic          load_pair;
   logic [1:0]    rd_pair;
   logic [AW-1:0] wr_addr;
   logic [AW-1:0] a_addr;
   logic [AW-1:0] b_addr;

   assign in_fire   = in_valid && in_ready;
   assign out_fire  = out_valid && out_ready;
   assign load_done = in_fire && (count == 3'd7);
   assign last_pair = (pair_idx == 2'd3);

   // Pair that goes into the output registers on the next load: the following
   // pair of the current frame, or pair 0 of a freshly completed frame.
   assign rd_pair = (state == EMIT && !last_pair) ? pair_idx + 2'd1 : 2'd0;

   // Pair k: a = x[bitrev3(2k)] = x[{0,k0,k1}], b = x[{1,k0,k1}].
`ifdef FFT_PINGPONG_EN
   logic load_bank;
   logic emit_bank;
   logic load_full;
   logic rd_bank;

   assign rd_bank  = (state == EMIT && !last_pair) ? emit_bank : load_bank;
   // The load bank may complete on the very edge pair 3 leaves; that still swaps.
   assign swap_now = (state == EMIT) && out_fire && last_pair && (load_full || load_done);
   assign wr_addr  = {load_bank, count};
   assign a_addr   = {rd_bank, 1'b0, rd_pair[0], rd_pair[1]};
   assign b_addr   = {rd_bank, 1'b1, rd_pair[0], rd_pair[1]};
`else
   assign swap_now = 1'b0;
   assign wr_addr  = count;
   assign a_addr   = {1'b0, rd_pair[0], rd_pair[1]};
   assign b_addr   = {1'b1, rd_pair[0], rd_pair[1]};
`endif

   assign load_pair = (state == LOAD && load_done) || (out_fire && (!last_pair || swap_now));

   // Sample storage needs no reset: the frame count alone decides what is valid.
   always_ff @(posedge clk) begin
      if (in_fire) begin
         mem_re[wr_addr] <= in_re;
         mem_im[wr_addr] <= in_im;
      end
   end

   // Pair 0 never reads x7, so loading it on the edge that writes x7 is safe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_re       <= '0;
         a_im       <= '0;
         b_re       <= '0;
         b_im       <= '0;
         out_idx    <= 2'd0;
         frame_last <= 1'b0;
      end else if (load_pair) begin
         a_re       <= mem_re[a_addr];
         a_im       <= mem_im[a_addr];
         b_re       <= mem_re[b_addr];
         b_im       <= mem_im[b_addr];
         out_idx    <= rd_pair;
         frame_last <= (rd_pair == 2'd3);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= LOAD;
         count     <= 3'd0;
         pair_idx  <= 2'd0;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
`ifdef FFT_PINGPONG_EN
         load_bank <= 1'b0;
         emit_bank <= 1'b0;
         load_full <= 1'b0;
`endif
      end else begin
         case (state)
            LOAD: begin
               if (in_fire) begin
                  count <= count + 3'd1;
               end
               if (load_done) begin
                  state     <= EMIT;
                  out_valid <= 1'b1;
                  pair_idx  <= 2'd0;
`ifdef FFT_PINGPONG_EN
                  emit_bank <= load_bank;
                  load_bank <= ~load_bank;
`else
                  in_ready  <= 1'b0;
`endif
               end
            end
            EMIT: begin
`ifdef FFT_PINGPONG_EN
               if (in_fire) begin
                  count <= count + 3'd1;
               end
               if (load_done) begin
                  load_full <= 1'b1;
                  in_ready  <= 1'b0;
               end
`endif
               if (out_fire) begin
                  if (!last_pair) begin
                     pair_idx <= pair_idx + 2'd1;
                  end else begin
                     pair_idx <= 2'd0;
`ifdef FFT_PINGPONG_EN
                     // These override the load_full/in_ready updates above when
                     // the last sample and pair 3 cross on the same edge.
                     if (swap_now) begin
                        emit_bank <= load_bank;
                        load_bank <= ~load_bank;
                        load_full <= 1'b0;
                        in_ready  <= 1'b1;
                     end else begin
                        state     <= LOAD;
                        out_valid <= 1'b0;
                     end
`else
                     state     <= LOAD;
                     out_valid <= 1'b0;
                     count     <= 3'd0;
                     in_ready  <= 1'b1;
`endif
                  end
               end
            end
            default: state <= LOAD;
         endcase
      end
   end

endmodule

// File: tb/tb_fft_input_reorder.sv
// tb/tb_fft_input_reorder.sv - scoreboard bench for fft_input_reorder
module tb_fft_input_reorder;

   localparam int W = 16;
`ifdef FFT_PINGPONG_EN
   localparam int EXP_POPS = 428;
`else
   localparam int EXP_POPS = 420;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_re;
   logic [W-1:0] in_im;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] a_re;
   logic [W-1:0] a_im;
   logic [W-1:0] b_re;
   logic [W-1:0] b_im;
   logic [1:0]   out_idx;
   logic         frame_last;

   always #5 clk = ~clk;

   fft_input_reorder #(.W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_re     (in_re),
      .in_im     (in_im),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .a_re      (a_re),
      .a_im      (a_im),
      .b_re      (b_re),
      .b_im      (b_im),
      .out_idx   (out_idx),
      .frame_last(frame_last)
   );

   typedef struct packed {
      logic [1:0]   idx;
      logic         last;
      logic [W-1:0] are;
      logic [W-1:0] aim;
      logic [W-1:0] bre;
      logic [W-1:0] bim;
   } pair_t;

   pair_t        exp_q[$];
   int           n_checks = 0;
   int           n_fail = 0;
   int           n_pops = 0;
   int           frames_out = 0;
   int           cont_checks = 0;
   logic [W-1:0] m_re [8];
   logic [W-1:0] m_im [8];
   int           m_cnt = 0;
   bit           have_hold = 0;
   bit           cont_pending = 0;
   bit           rand_done = 0;
   pair_t        held;
   pair_t        cur;
   pair_t        want;
   int           a_tab [4] = '{0, 2, 1, 3};
   int           b_tab [4] = '{4, 6, 5, 7};

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Monitor and scoreboard: captures accepted samples, builds expected pairs per
   // completed frame, and checks every emitted pair and every stalled cycle.
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         m_cnt = 0;
         have_hold = 0;
         cont_pending = 0;
      end else begin
         cur = {out_idx, frame_last, a_re, a_im, b_re, b_im};
         if (cont_pending) begin
            chk("no_bubble", 128'(out_valid), 128'(1));
            cont_checks++;
            cont_pending = 0;
         end
         if (have_hold && out_valid) chk("hold_stable", 128'(cur), 128'(held));
`ifndef FFT_PINGPONG_EN
         if (out_valid) chk("in_ready_low_in_emit", 128'(in_ready), 128'(0));
`endif
         if (in_valid && in_ready) begin
            m_re[m_cnt] = in_re;
            m_im[m_cnt] = in_im;
            m_cnt++;
            if (m_cnt == 8) begin
               for (int k = 0; k < 4; k++) begin
                  want.idx  = 2'(k);
                  want.last = (k == 3);
                  want.are  = m_re[a_tab[k]];
                  want.aim  = m_im[a_tab[k]];
                  want.bre  = m_re[b_tab[k]];
                  want.bim  = m_im[b_tab[k]];
                  exp_q.push_back(want);
               end
               m_cnt = 0;
            end
         end
         if (out_valid && out_ready) begin
            have_hold = 0;
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_pair: got %0h expected none", cur);
            end else begin
               want = exp_q.pop_front();
               chk("pair", 128'(cur), 128'(want));
               n_pops++;
               if (want.idx == 2'd3) begin
                  frames_out++;
                  if (exp_q.size() > 0) cont_pending = 1;
               end
            end
         end else begin
            have_hold = out_valid;
            held = cur;
         end
      end
   end

   task automatic send_sample(input logic [W-1:0] re, input logic [W-1:0] im);
      int  t = 0;
      bit  fired = 0;
      in_valid = 1'b1;
      in_re = re;
      in_im = im;
      while (!fired && t < 300) begin
         @(negedge clk);
         fired = in_ready;
         @(posedge clk);
         #1;
         t++;
      end
      if (!fired) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_timeout: got in_ready 0 for %0d cycles expected acceptance", t);
      end
   endtask

   task automatic send_frame(input int base_re, input int base_im);
      for (int i = 0; i < 8; i++) send_sample(W'(base_re + i), W'(base_im + i));
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int t = 0;
      while ((exp_q.size() != 0 || out_valid) && t < 2000) begin
         @(posedge clk);
         #1;
         t++;
      end
      chk("drain", 128'(exp_q.size() != 0 || out_valid), 128'(0));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish within 50000 cycles");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [W-1:0] rr;
      logic [W-1:0] ri;
      int           fo;
      int           cc;

      rst = 1'b1;
      in_valid = 1'b0;
      in_re = '0;
      in_im = '0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", 128'({out_valid, a_re, a_im, b_re, b_im, out_idx, frame_last}), 128'(0));
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("reset_in_ready", 128'(in_ready), 128'(1));

      // Basic frame, latency of one cycle after x7
      for (int i = 0; i < 8; i++) begin
         send_sample(W'(i), W'(100 + i));
         if (i == 6) chk("no_early_valid", 128'(out_valid), 128'(0));
         if (i == 7) begin
            chk("latency_1", 128'(out_valid), 128'(1));
            chk("first_pair", 128'({a_re, a_im, b_re, b_im, out_idx}),
                128'({16'd0, 16'd100, 16'd4, 16'd104, 2'd0}));
         end
      end
      in_valid = 1'b0;
      wait_drain();

      // Three-cycle stall on pair 1
      fork
         send_frame(0, 100);
         begin
            int t = 0;
            do begin
               @(negedge clk);
               t++;
            end while (!(out_valid && out_idx == 2'd0) && t < 100);
            chk("stall_pair0_seen", 128'(out_valid && out_idx == 2'd0), 128'(1));
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            @(negedge clk);
            chk("stall_pair1", 128'({out_valid, a_re, a_im, b_re, b_im, out_idx}),
                128'({1'b1, 16'd2, 16'd102, 16'd6, 16'd106, 2'd1}));
            repeat (3) @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      wait_drain();

      // in_valid held high into the next frame
      fo = frames_out;
      for (int i = 0; i < 8; i++) send_sample(W'(40 + i), W'(140 + i));
      send_sample(16'd50, 16'd150);
`ifdef FFT_PINGPONG_EN
      chk("accept_during_emit", 128'(frames_out - fo), 128'(0));
`else
      chk("accept_after_pair3", 128'(frames_out - fo), 128'(1));
`endif
      for (int i = 1; i < 8; i++) send_sample(W'(50 + i), W'(150 + i));
      in_valid = 1'b0;
      wait_drain();

`ifdef FFT_PINGPONG_EN
      // Second frame loads while the first waits; pair (10,14) follows (3,7) directly
      out_ready = 1'b0;
      cc = cont_checks;
      for (int i = 0; i < 8; i++) send_sample(W'(i), W'(100 + i));
      for (int i = 0; i < 8; i++) send_sample(W'(10 + i), W'(110 + i));
      in_valid = 1'b0;
      chk("pp_full_in_ready_low", 128'(in_ready), 128'(0));
      out_ready = 1'b1;
      wait_drain();
      chk("pp_back_to_back", 128'(cont_checks - cc), 128'(1));
`endif

      // Reset after a partial frame
      for (int i = 0; i < 5; i++) send_sample(W'(i), W'(100 + i));
      in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_out_valid", 128'(out_valid), 128'(0));
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_in_ready", 128'(in_ready), 128'(1));
      for (int i = 20; i < 28; i++) begin
         send_sample(W'(i), W'(100 + i));
         if (i == 27) chk("post_rst_pair0", 128'({a_re, a_im, b_re, b_im}),
                          128'({16'd20, 16'd120, 16'd24, 16'd124}));
      end
      in_valid = 1'b0;
      wait_drain();

      // Reset while a buffered frame waits to emit
      out_ready = 1'b0;
      send_frame(30, 130);
      @(posedge clk);
      #1;
      chk("emit_before_rst", 128'({out_valid, a_re}), 128'({1'b1, 16'd30}));
      #2;
      rst = 1'b1;
      #1;
      chk("rst_async_clear", 128'({out_valid, a_re, b_re}), 128'(0));
      @(posedge clk);
      #1;
      rst = 1'b0;
      out_ready = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      chk("discarded_absent", 128'(out_valid), 128'(0));

      // Random stalls on both sides over 100 frames
      fork
         begin
            for (int f = 0; f < 100; f++) begin
               for (int i = 0; i < 8; i++) begin
                  if ($urandom_range(0, 3) == 0) begin
                     in_valid = 1'b0;
                     @(posedge clk);
                     #1;
                  end
                  rr = W'($urandom);
                  ri = W'($urandom);
                  send_sample(rr, ri);
               end
            end
            in_valid = 1'b0;
            wait_drain();
            rand_done = 1;
         end
         begin
            while (!rand_done) begin
               out_ready = ($urandom_range(0, 3) != 0);
               @(posedge clk);
               #1;
            end
            out_ready = 1'b1;
         end
      join

      chk("total_pairs", 128'(n_pops), 128'(EXP_POPS));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
